// File: rtl/status_register_if.sv
// Status-register bus: EXE flag inputs, MSR write port and status views.
interface status_register_if #(
  parameter int unsigned CNT_W = 8
);
  logic [3:0]       alu_status;
  logic             s_en;
  logic             exe_valid;
  logic             cond_pass;
  logic             flush;
  logic             freeze;
  logic             msr_wr;
  logic [3:0]       msr_mask;
  logic [3:0]       msr_data;
  logic             clr_sticky;
  logic [3:0]       status;
  logic [3:0]       status_fwd;
  logic             sticky_v;
  logic [CNT_W-1:0] upd_cnt;
  logic             upd_pulse;

  // Pipeline/control side drives requests and observes the status views.
  modport master (
    output alu_status, s_en, exe_valid, cond_pass, flush, freeze,
           msr_wr, msr_mask, msr_data, clr_sticky,
    input  status, status_fwd, sticky_v, upd_cnt, upd_pulse
  );

  // Status register side.
  modport slave (
    input  alu_status, s_en, exe_valid, cond_pass, flush, freeze,
           msr_wr, msr_mask, msr_data, clr_sticky,
    output status, status_fwd, sticky_v, upd_cnt, upd_pulse
  );
endinterface

// File: rtl/status_register.sv
// Producer of the {z,c,n,v} status nibble: ALU flag latch, masked MSR write,
// freeze/flush gating, sticky overflow and saturating update counter.
module status_register #(
  parameter int unsigned CNT_W       = 8,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input logic              clk,
  input logic              rst_n,
  status_register_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [3:0]       status_q;
  logic [3:0]       next_status;
  logic             sticky_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pulse_q;
  logic             alu_upd;
  logic             msr_upd;
  logic             sticky_set;

  assign alu_upd = bus.exe_valid & bus.s_en & bus.cond_pass & ~bus.flush & ~bus.freeze;
  // Flush only squashes the EXE instruction; an MSR write is independent of it.
  assign msr_upd = bus.msr_wr & ~bus.freeze;

  // Per-bit next status: MSR owns masked bits, ALU owns the rest.
  always_comb begin
    next_status = status_q;
    for (int i = 0; i < 4; i++) begin
      if (msr_upd && bus.msr_mask[i]) begin
        next_status[i] = bus.msr_data[i];
      end else if (alu_upd) begin
        next_status[i] = bus.alu_status[i];
      end
    end
  end

  assign sticky_set = next_status[0] & (alu_upd | (msr_upd & bus.msr_mask[0]));

  // State update; freeze holds everything because both update enables drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= RESET_FLAGS;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      status_q <= next_status;
      if (sticky_set) begin
        sticky_q <= 1'b1;
      end else if (bus.clr_sticky && !bus.freeze) begin
        sticky_q <= 1'b0;
      end
      if (alu_upd && cnt_q != CntMax) begin
        cnt_q <= cnt_q + 1'b1;
      end
      pulse_q <= alu_upd;
    end
  end

  assign bus.status     = status_q;
  assign bus.status_fwd = next_status;
  assign bus.sticky_v   = sticky_q;
  assign bus.upd_cnt    = cnt_q;
  assign bus.upd_pulse  = pulse_q;

endmodule

// File: tb/tb_status_register.sv
// Directed bench for status_register: a CNT_W=8 instance for the main
// sequence and a CNT_W=2 instance for counter saturation.
module tb_status_register;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  status_register_if #(.CNT_W(8)) bus ();
  status_register_if #(.CNT_W(2)) bus2 ();

  status_register #(.CNT_W(8), .RESET_FLAGS(4'b0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  status_register #(.CNT_W(2), .RESET_FLAGS(4'b0000)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.alu_status = 4'b0000;
    bus.s_en       = 1'b0;
    bus.exe_valid  = 1'b0;
    bus.cond_pass  = 1'b0;
    bus.flush      = 1'b0;
    bus.freeze     = 1'b0;
    bus.msr_wr     = 1'b0;
    bus.msr_mask   = 4'b0000;
    bus.msr_data   = 4'b0000;
    bus.clr_sticky = 1'b0;
  endtask

  task automatic alu_req(input logic [3:0] flags);
    bus.alu_status = flags;
    bus.exe_valid  = 1'b1;
    bus.s_en       = 1'b1;
    bus.cond_pass  = 1'b1;
  endtask

  task automatic msr_req(input logic [3:0] mask, input logic [3:0] data);
    bus.msr_wr   = 1'b1;
    bus.msr_mask = mask;
    bus.msr_data = data;
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

    clear_inputs();
    bus2.alu_status = 4'b0000;
    bus2.s_en       = 1'b0;
    bus2.exe_valid  = 1'b0;
    bus2.cond_pass  = 1'b0;
    bus2.flush      = 1'b0;
    bus2.freeze     = 1'b0;
    bus2.msr_wr     = 1'b0;
    bus2.msr_mask   = 4'b0000;
    bus2.msr_data   = 4'b0000;
    bus2.clr_sticky = 1'b0;
    rst_n = 1'b0;
    #3;
    check("reset_status", 32'(bus.status), 32'h0);
    check("reset_fwd", 32'(bus.status_fwd), 32'h0);
    check("reset_sticky", 32'(bus.sticky_v), 32'h0);
    check("reset_cnt", 32'(bus.upd_cnt), 32'h0);
    check("reset_pulse", 32'(bus.upd_pulse), 32'h0);
    #5;
    rst_n = 1'b1;
    step();

    // Gated updates: s_en=0, then s_en=1, then flush.
    bus.alu_status = 4'b0110;
    bus.exe_valid  = 1'b1;
    bus.cond_pass  = 1'b1;
    bus.s_en       = 1'b0;
    step();
    check("gate_s_en0_status", 32'(bus.status), 32'h0);
    check("gate_s_en0_cnt", 32'(bus.upd_cnt), 32'h0);
    bus.s_en = 1'b1;
    step();
    check("gate_upd_status", 32'(bus.status), 32'h6);
    check("gate_upd_cnt", 32'(bus.upd_cnt), 32'h1);
    check("gate_upd_pulse", 32'(bus.upd_pulse), 32'h1);
    bus.flush = 1'b1;
    step();
    check("gate_flush_status", 32'(bus.status), 32'h6);
    check("gate_flush_cnt", 32'(bus.upd_cnt), 32'h1);
    check("gate_flush_pulse", 32'(bus.upd_pulse), 32'h0);
    check("gate_sticky", 32'(bus.sticky_v), 32'h0);
    clear_inputs();

    // Bring status back to 0000 via MSR; MSR does not count.
    msr_req(4'b1111, 4'b0000);
    step();
    check("msr_zero_status", 32'(bus.status), 32'h0);
    check("msr_zero_cnt", 32'(bus.upd_cnt), 32'h1);
    check("msr_zero_pulse", 32'(bus.upd_pulse), 32'h0);
    clear_inputs();

    // MSR/ALU collision: MSR owns z,c; ALU owns n,v.
    alu_req(4'b1111);
    msr_req(4'b1100, 4'b0100);
    #1;
    check("coll_fwd", 32'(bus.status_fwd), 32'h7);
    step();
    check("coll_status", 32'(bus.status), 32'h7);
    check("coll_cnt", 32'(bus.upd_cnt), 32'h2);
    check("coll_sticky", 32'(bus.sticky_v), 32'h1);
    clear_inputs();

    // Sticky precedence: clear, then set+clear together, then clear alone.
    bus.clr_sticky = 1'b1;
    step();
    check("stk_clear", 32'(bus.sticky_v), 32'h0);
    alu_req(4'b0001);
    step();
    check("stk_set_wins", 32'(bus.sticky_v), 32'h1);
    check("stk_status", 32'(bus.status), 32'h1);
    check("stk_cnt", 32'(bus.upd_cnt), 32'h3);
    clear_inputs();
    bus.clr_sticky = 1'b1;
    step();
    check("stk_cleared", 32'(bus.sticky_v), 32'h0);
    clear_inputs();

    // Load 0101 by MSR; v=1 through mask[0] sets sticky.
    msr_req(4'b1111, 4'b0101);
    step();
    check("load_status", 32'(bus.status), 32'h5);
    check("load_sticky", 32'(bus.sticky_v), 32'h1);
    clear_inputs();

    // Freeze holds everything, including sticky against clr_sticky.
    bus.freeze = 1'b1;
    alu_req(4'b1010);
    msr_req(4'b1111, 4'b1010);
    bus.clr_sticky = 1'b1;
    #1;
    check("frz_fwd", 32'(bus.status_fwd), 32'h5);
    step();
    check("frz_status", 32'(bus.status), 32'h5);
    check("frz_cnt", 32'(bus.upd_cnt), 32'h3);
    check("frz_pulse", 32'(bus.upd_pulse), 32'h0);
    check("frz_sticky", 32'(bus.sticky_v), 32'h1);
    clear_inputs();

    // Flush squashes the ALU update but not the MSR write.
    alu_req(4'b1111);
    bus.flush = 1'b1;
    msr_req(4'b1000, 4'b1000);
    step();
    check("flush_msr_status", 32'(bus.status), 32'hD);
    check("flush_msr_cnt", 32'(bus.upd_cnt), 32'h3);
    clear_inputs();

    // cond_pass=0 and exe_valid=0 each block the update.
    alu_req(4'b0000);
    bus.cond_pass = 1'b0;
    step();
    check("nocond_status", 32'(bus.status), 32'hD);
    bus.cond_pass = 1'b1;
    bus.exe_valid = 1'b0;
    step();
    check("bubble_status", 32'(bus.status), 32'hD);
    check("bubble_cnt", 32'(bus.upd_cnt), 32'h3);
    clear_inputs();

    // Reach status=1011, cnt=5, then reset asynchronously between edges.
    alu_req(4'b1011);
    step();
    step();
    check("pre_rst_status", 32'(bus.status), 32'hB);
    check("pre_rst_cnt", 32'(bus.upd_cnt), 32'h5);
    clear_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_status", 32'(bus.status), 32'h0);
    check("async_rst_cnt", 32'(bus.upd_cnt), 32'h0);
    check("async_rst_sticky", 32'(bus.sticky_v), 32'h0);
    check("async_rst_pulse", 32'(bus.upd_pulse), 32'h0);
    #2;
    rst_n = 1'b1;
    step();

    // Saturation on the CNT_W=2 instance.
    bus2.exe_valid = 1'b1;
    bus2.s_en      = 1'b1;
    bus2.cond_pass = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("sat_cnt_%0d", i), 32'(bus2.upd_cnt), 32'(sat_exp[i]));
    end
    bus2.exe_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
